// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : PC generation, single-outstanding imem fetch and a small
//                instruction/PC buffer feeding decode, with redirect flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int                     WORDSIZE    = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [WORDSIZE-1:0]    RESET_PC    = '0,
    parameter int                     FIFO_DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [WORDSIZE-1:0]       imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0]    imem_resp_data,
    input  logic                      redirect_valid,
    input  logic [WORDSIZE-1:0]       redirect_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INSTR_WIDTH-1:0]    out_instr,
    output logic [WORDSIZE-1:0]       out_pc
);

    localparam int                    c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                    c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]    c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [WORDSIZE-1:0]   c_pc_step = WORDSIZE'(4);
    localparam logic [WORDSIZE-1:0]   c_align   = ~WORDSIZE'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WORDSIZE-1:0]     fetch_pc_q, fetch_pc_d;
    logic [WORDSIZE-1:0]     req_pc_q, req_pc_d;
    logic                    drop_q, drop_d;
    logic                    stale_q, stale_d;
    logic [c_ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_cnt_w-1:0]      count_q, count_d;
    logic [INSTR_WIDTH-1:0]  fifo_instr_q [FIFO_DEPTH];
    logic [INSTR_WIDTH-1:0]  fifo_instr_d [FIFO_DEPTH];
    logic [WORDSIZE-1:0]     fifo_pc_q    [FIFO_DEPTH];
    logic [WORDSIZE-1:0]     fifo_pc_d    [FIFO_DEPTH];

    logic                    w_accept;
    logic                    w_resp_hit;
    logic                    w_push;
    logic                    w_pop;
    logic [c_cnt_w-1:0]      w_count_next;
    logic [WORDSIZE-1:0]     w_redirect_target;

    assign w_redirect_target = redirect_pc & c_align;
    assign w_accept          = (state_q == ST_REQ) && imem_req_ready;
    assign w_resp_hit        = (state_q == ST_WAIT) && imem_resp_valid;
    assign w_push            = w_resp_hit && !drop_q && !redirect_valid;
    assign w_pop             = (count_q != '0) && out_ready && !redirect_valid;

    // A redirect empties the buffer regardless of any same-cycle push/pop
    always_comb begin
        w_count_next = count_q;
        if (redirect_valid) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = count_q + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = count_q - c_cnt_w'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        stale_d      = stale_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = w_count_next;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (w_push) begin
            fifo_instr_d[wr_ptr_q] = imem_resp_data;
            fifo_pc_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d               = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if ((count_q < c_depth) && !redirect_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_accept) begin
                    // A stale request already had fetch_pc replaced by the target
                    state_d  = ST_WAIT;
                    stale_d  = 1'b0;
                    req_pc_d = stale_q ? req_pc_q : fetch_pc_q;
                    if (stale_q || redirect_valid) begin
                        drop_d = 1'b1;
                    end
                    if (!stale_q) begin
                        fetch_pc_d = fetch_pc_q + c_pc_step;
                    end
                end else if (redirect_valid && !stale_q) begin
                    stale_d  = 1'b1;
                    req_pc_d = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (w_resp_hit) begin
                    drop_d  = 1'b0;
                    state_d = (w_count_next < c_depth) ? ST_REQ : ST_IDLE;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_d = w_redirect_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            stale_q    <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            stale_q      <= stale_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = (state_q != ST_REQ) ? '0 : (stale_q ? req_pc_q : fetch_pc_q);
    assign out_valid      = (count_q != '0);
    assign out_instr      = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc         = out_valid ? fifo_pc_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire
